// File: rtl/riscv_lsu_ctrl.sv
// rtl/riscv_lsu_ctrl.sv - RISC-V load/store sequencer driving a req/gnt/rvalid data bus with timeout watchdog
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_CHECK_EN.
module riscv_lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_bus_err_o,
    output logic        lsu_misalign_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic [15:0] cnt_q;

    logic        in_byte;
    logic        in_half;
    logic [1:0]  in_off;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;
    logic        timeout;
    logic [31:0] rd_shift;
    logic [31:0] rd_fmt;

    // Size encoding: [1:0]==0 byte, ==1 half, anything else word; bit 2 selects zero-extension.
    always_comb begin
        in_byte  = (lsu_size_i[1:0] == 2'd0);
        in_half  = (lsu_size_i[1:0] == 2'd1);
        in_off   = 2'b00;
        in_be    = 4'b1111;
        in_wdata = lsu_wdata_i;
        if (in_byte) begin
            in_off   = lsu_addr_i[1:0];
            in_be    = 4'b0001 << lsu_addr_i[1:0];
            in_wdata = {4{lsu_wdata_i[7:0]}};
        end else if (in_half) begin
            in_off   = {lsu_addr_i[1], 1'b0};
            in_be    = 4'b0011 << {lsu_addr_i[1], 1'b0};
            in_wdata = {2{lsu_wdata_i[15:0]}};
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic in_misalign;
    assign in_misalign = (in_half && lsu_addr_i[0]) ||
                         (!in_byte && !in_half && (lsu_addr_i[1:0] != 2'b00));
`endif

    always_comb begin
        rd_shift = data_rdata_i >> {off_q, 3'b000};
        case (size_q)
            3'd0:    rd_fmt = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd4:    rd_fmt = {24'd0, rd_shift[7:0]};
            3'd1:    rd_fmt = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd5:    rd_fmt = {16'd0, rd_shift[15:0]};
            default: rd_fmt = rd_shift;
        endcase
    end

    // >= rather than == so a grant landing on the last budget cycle still aborts promptly in RESP.
    assign timeout = (cnt_q >= TIMEOUT_LAST);

    assign lsu_stall_req_o = arstn_i & lsu_req_i & (state_q != DONE);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q        <= IDLE;
            size_q         <= 3'd0;
            off_q          <= 2'd0;
            cnt_q          <= 16'd0;
            lsu_rdata_o    <= 32'd0;
            lsu_bus_err_o  <= 1'b0;
            lsu_misalign_o <= 1'b0;
            data_req_o     <= 1'b0;
            data_we_o      <= 1'b0;
            data_be_o      <= 4'd0;
            data_addr_o    <= 32'd0;
            data_wdata_o   <= 32'd0;
        end else begin
            lsu_bus_err_o  <= 1'b0;
            lsu_misalign_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= 16'd0;
                    if (lsu_req_i) begin
                        size_q       <= lsu_size_i;
                        off_q        <= in_off;
                        data_we_o    <= lsu_we_i;
                        data_be_o    <= in_be;
                        data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
                        data_wdata_o <= in_wdata;
`ifdef LSU_MISALIGN_CHECK_EN
                        if (in_misalign) begin
                            state_q        <= DONE;
                            lsu_misalign_o <= 1'b1;
                            if (!lsu_we_i) lsu_rdata_o <= 32'd0;
                        end else begin
                            state_q    <= REQ;
                            data_req_o <= 1'b1;
                        end
`else
                        state_q    <= REQ;
                        data_req_o <= 1'b1;
`endif
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        state_q    <= data_we_o ? DONE : RESP;
                    end else if (timeout) begin
                        data_req_o    <= 1'b0;
                        state_q       <= DONE;
                        lsu_bus_err_o <= 1'b1;
                        if (!data_we_o) lsu_rdata_o <= 32'd0;
                    end
                end
                RESP: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (data_rvalid_i) begin
                        lsu_rdata_o <= rd_fmt;
                        state_q     <= DONE;
                    end else if (timeout) begin
                        lsu_rdata_o   <= 32'd0;
                        lsu_bus_err_o <= 1'b1;
                        state_q       <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
